// File: rtl/preproc_frame_sched_pkg.sv
// Shared definitions for frame-level controllers: state encoding and the
// minimum frame dimension accepted by the 3x3 filter pipeline.
package preproc_frame_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LINE  = 3'd1,
    ST_HBLK  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } frame_state_e;

  localparam int unsigned MIN_DIM = 3;

  function automatic logic dims_ok(input int unsigned w, input int unsigned h);
    return (w >= MIN_DIM) && (h >= MIN_DIM);
  endfunction

endpackage

// File: rtl/preproc_frame_sched_valid_delay_line.sv
// Shift register that delays the read strobe by the memory latency and
// reports whether any strobe is still travelling toward the pipeline.
module valid_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic vld_in,
  output logic vld_out,
  output logic in_flight
);

  logic [DEPTH-1:0] vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (clr) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | DEPTH'(vld_in);
    end
  end

  assign vld_out   = vld_pipe[DEPTH-1];
  assign in_flight = |vld_pipe;

endmodule

// File: rtl/preproc_frame_sched.sv
// Frame sequencer for the gray/Gaussian preprocessing pipeline: raster read
// requests with per-line blanking, output counting and drain detection.
module preproc_frame_sched
  import preproc_frame_sched_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int DIM_W      = 12,
  parameter int HBLANK     = 4,
  parameter int MEM_LAT    = 1,
  parameter int DRAIN_IDLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DIM_W-1:0]     cfg_width,
  input  logic [DIM_W-1:0]     cfg_height,
  input  logic [ADDR_W-1:0]    cfg_base,
  input  logic                 stall,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  output logic                 pp_din_valid,
  output logic [DIM_W-1:0]     pp_img_width,
  input  logic                 pp_dout_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 err_cfg,
  output logic [2*DIM_W-1:0]   out_cnt
);

  localparam logic [7:0] BLANK_LAST = (HBLANK == 0) ? 8'd0 : 8'(HBLANK - 1);
  localparam logic [7:0] IDLE_LAST  = 8'(DRAIN_IDLE - 1);

  frame_state_e        state, state_nxt;
  logic [DIM_W-1:0]    width_q, height_q, pix, line;
  logic [ADDR_W-1:0]   addr;
  logic [7:0]          blank_cnt, idle_cnt;
  logic                issue, accept, reject;
  logic                last_pix, last_line, blank_end, drain_hold, in_flight;

  function automatic logic [2*DIM_W-1:0] sat_inc(input logic [2*DIM_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign last_pix   = (pix == width_q - 1'b1);
  assign last_line  = (line == height_q - 1'b1);
  assign blank_end  = (blank_cnt == BLANK_LAST);
  // A read is still pending while its strobe is registered or in the delay line.
  assign drain_hold = pp_dout_valid | in_flight | mem_rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (dims_ok(32'(cfg_width), 32'(cfg_height))) begin
            accept    = 1'b1;
            state_nxt = ST_LINE;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_LINE: begin
        if (!stall) begin
          issue = 1'b1;
          if (last_pix) begin
            if (HBLANK == 0) state_nxt = last_line ? ST_DRAIN : ST_LINE;
            else             state_nxt = ST_HBLK;
          end
        end
      end
      ST_HBLK: begin
        if (blank_end) state_nxt = (line == height_q) ? ST_DRAIN : ST_LINE;
      end
      ST_DRAIN: begin
        if (!drain_hold && idle_cnt == IDLE_LAST) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
      issue     = 1'b0;
      accept    = 1'b0;
      reject    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      width_q     <= '0;
      height_q    <= '0;
      addr        <= '0;
      pix         <= '0;
      line        <= '0;
      blank_cnt   <= '0;
      idle_cnt    <= '0;
      err_cfg     <= 1'b0;
      out_cnt     <= '0;
    end else begin
      mem_rd_en <= issue;
      err_cfg   <= reject;
      if (issue) mem_rd_addr <= addr;
      if (accept) begin
        width_q  <= cfg_width;
        height_q <= cfg_height;
        addr     <= cfg_base;
        pix      <= '0;
        line     <= '0;
      end else if (issue) begin
        addr <= addr + 1'b1;
        if (last_pix) begin
          pix  <= '0;
          line <= line + 1'b1;
        end else begin
          pix <= pix + 1'b1;
        end
      end
      blank_cnt <= (state == ST_HBLK) ? blank_cnt + 1'b1 : 8'd0;
      idle_cnt  <= (state == ST_DRAIN && !drain_hold) ? idle_cnt + 1'b1 : 8'd0;
      if (accept)                                              out_cnt <= '0;
      else if (state != ST_IDLE && pp_dout_valid && !abort)    out_cnt <= sat_inc(out_cnt);
    end
  end

  valid_delay_line #(.DEPTH(MEM_LAT)) u_vld_dly (
    .clk       (clk),
    .rst       (rst),
    .clr       (abort),
    .vld_in    (mem_rd_en),
    .vld_out   (pp_din_valid),
    .in_flight (in_flight)
  );

  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  assign pp_img_width = width_q;

endmodule
